polyphase_downsampler: RTL and testbench

Rational-rate decimator converting the 44.1 kHz signed 16-bit input stream to the ~27.4 kHz stream used by the analysis path, the reverse of the output-side upsampler. An 8-tap, 16-phase polyphase anti-alias FIR is evaluated by one time-shared MAC. A 16-bit phase accumulator selects the coefficient bank on each output.

---
 rtl/ds_pkg.sv | 14 +
 rtl/ds_coeff_rom.sv | 24 ++
 rtl/polyphase_downsampler.sv | 134 +++++++++++++
 tb/tb_polyphase_downsampler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ds_pkg.sv
// rtl/ds_pkg.sv - shared widths, geometry and FSM states for polyphase_downsampler
package ds_pkg;
  localparam int SAMPLE_W = 16;
  localparam int COEFF_W  = 16;
  localparam int ACC_W    = 35;
  localparam int TAPS     = 8;
  localparam int PHASES   = 16;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } ds_state_e;
endpackage

// File: rtl/ds_coeff_rom.sv
// rtl/ds_coeff_rom.sv - 16-phase x 8-tap Q1.15 anti-alias coefficients, each bank sums to 32768
module ds_coeff_rom
  import ds_pkg::*;
(
  input  logic [3:0]                phase_i,
  input  logic [2:0]                tap_i,
  output logic signed [COEFF_W-1:0] coeff_o
);

  logic signed [COEFF_W-1:0] skew;

  // Phase moves weight between the two centre taps, so every bank keeps unity DC gain.
  always_comb begin
    skew = $signed({4'b0000, phase_i, 8'h00}) - 16'sd2048;
    case (tap_i)
      3'd0, 3'd7: coeff_o = -16'sd512;
      3'd1, 3'd6: coeff_o = 16'sd1536;
      3'd2, 3'd5: coeff_o = 16'sd4096;
      3'd3:       coeff_o = 16'sd11264 + skew;
      default:    coeff_o = 16'sd11264 - skew;
    endcase
  end

endmodule

// File: rtl/polyphase_downsampler.sv
// rtl/polyphase_downsampler.sv - 44.1k -> ~27.4k polyphase decimator with one time-shared MAC
// Optional output saturation is enabled by defining DS_SATURATE_EN.
module polyphase_downsampler
  import ds_pkg::*;
#(
  parameter int unsigned STEP   = 40718,
  parameter int          TAPS   = ds_pkg::TAPS,
  parameter int          PHASES = ds_pkg::PHASES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  input  logic                       valid_in,
  output logic signed [SAMPLE_W-1:0] out_sample,
  output logic                       valid_out,
  output logic                       busy,
  output logic                       overrun
);

  localparam int PTR_W = $clog2(TAPS);
  localparam int PH_W  = $clog2(PHASES);

  ds_state_e                 state_q;
  logic signed [SAMPLE_W-1:0] buf_q [TAPS];
  logic [PTR_W-1:0]          wr_ptr_q;
  logic [PTR_W-1:0]          base_q;
  logic [PTR_W-1:0]          k_q;
  logic [15:0]               acc_q;
  logic [PH_W-1:0]           phase_q;
  logic signed [ACC_W-1:0]   sum_q;
  logic signed [SAMPLE_W-1:0] res_q;
  logic signed [SAMPLE_W-1:0] out_q;
  logic                      valid_q;
  logic                      overrun_q;
  logic                      fin_q;

  logic [16:0]                 acc_d;
  logic [PTR_W-1:0]            rd_idx;
  logic signed [COEFF_W-1:0]   coeff;
  logic signed [2*SAMPLE_W-1:0] prod;
  logic signed [ACC_W-1:0]     sum_d;
  logic signed [ACC_W-1:0]     rnd;
  logic signed [SAMPLE_W-1:0]  res_d;
  logic                        rnd_lo_unused;

  assign acc_d  = {1'b0, acc_q} + 17'(STEP);
  assign rd_idx = base_q - PTR_W'(1) - k_q;
  assign prod   = buf_q[rd_idx] * coeff;
  assign sum_d  = sum_q + {{(ACC_W-2*SAMPLE_W){prod[2*SAMPLE_W-1]}}, prod};
  assign rnd    = sum_q + ACC_W'(16384);
  assign rnd_lo_unused = ^rnd[14:0];

  ds_coeff_rom u_rom (
    .phase_i (4'(phase_q)),
    .tap_i   (3'(k_q)),
    .coeff_o (coeff)
  );

`ifdef DS_SATURATE_EN
  always_comb begin
    res_d = rnd[30:15];
    if (rnd[ACC_W-1:30] != {(ACC_W-30){rnd[30]}}) begin
      res_d = rnd[ACC_W-1] ? 16'sh8000 : 16'sh7fff;
    end
  end
`else
  logic rnd_hi_unused;
  assign rnd_hi_unused = ^rnd[ACC_W-1:31];
  assign res_d = rnd[30:15];
`endif

  // OUT spends two cycles: round/saturate into res_q, then publish it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      base_q    <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      phase_q   <= '0;
      sum_q     <= '0;
      res_q     <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      fin_q     <= 1'b0;
      for (int i = 0; i < TAPS; i++) buf_q[i] <= '0;
    end else begin
      valid_q <= 1'b0;
      if (valid_in && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            buf_q[wr_ptr_q] <= in_sample;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            acc_q           <= acc_d[15:0];
            if (acc_d[16]) begin
              phase_q <= acc_d[15 -: PH_W];
              base_q  <= wr_ptr_q + PTR_W'(1);
              k_q     <= '0;
              sum_q   <= '0;
              state_q <= MAC;
            end
          end
        end
        MAC: begin
          sum_q <= sum_d;
          k_q   <= k_q + PTR_W'(1);
          if (k_q == PTR_W'(TAPS - 1)) begin
            fin_q   <= 1'b0;
            state_q <= OUT;
          end
        end
        OUT: begin
          if (!fin_q) begin
            res_q <= res_d;
            fin_q <= 1'b1;
          end else begin
            out_q   <= res_q;
            valid_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_sample = out_q;
  assign valid_out  = valid_q;
  assign busy       = (state_q != IDLE);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_polyphase_downsampler.sv
// tb/tb_polyphase_downsampler.sv - randomized scoreboard bench for polyphase_downsampler
module tb_polyphase_downsampler;
  localparam int STEP = 40718;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] in_sample = '0;
  logic               valid_in = 1'b0;
  logic signed [15:0] out_sample;
  logic               valid_out;
  logic               busy;
  logic               overrun;

  polyphase_downsampler dut (
    .clk        (clk),
    .reset      (reset),
    .in_sample  (in_sample),
    .valid_in   (valid_in),
    .out_sample (out_sample),
    .valid_out  (valid_out),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_pass = 0;
  int     exp_q[$];
  longint hist[$];
  longint acc_m;
  int     n_pushed = 0;
  int     n_out = 0;
  longint cyc = 0;
  longint last_out_cyc = -1;
  longint min_gap = 1000000;
  int     last_out = 0;
  bit     dc_mode = 0;
  int     dc_seen = 0;
  int     dc_bad = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic longint coeff(input int p, input int k);
    longint base[8] = '{-512, 1536, 4096, 11264, 11264, 4096, 1536, -512};
    longint delta = 256 * (p - 8);
    if (k == 3) return base[k] + delta;
    if (k == 4) return base[k] - delta;
    return base[k];
  endfunction

  // Filter output as arithmetic on the last eight accepted samples.
  function automatic int filter_out(input int p);
    longint s = 0;
    longint v;
    for (int k = 0; k < 8; k++) s += hist[7 - k] * coeff(p, k);
    v = (s + 16384) >>> 15;
`ifdef DS_SATURATE_EN
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`else
    v = ((v + 32768) % 65536 + 65536) % 65536 - 32768;
`endif
    return int'(v);
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 8; i++) hist.push_back(0);
    acc_m = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input longint x);
    hist.push_back(x);
    void'(hist.pop_front());
    acc_m += STEP;
    if (acc_m >= 65536) begin
      acc_m -= 65536;
      exp_q.push_back(filter_out(int'(acc_m >> 12)));
      n_pushed++;
    end
  endtask

  function automatic bit will_carry();
    return (acc_m + STEP) >= 65536;
  endfunction

  always @(negedge clk) begin
    if (valid_out) begin
      n_out++;
      if (last_out_cyc >= 0 && cyc - last_out_cyc < min_gap) min_gap = cyc - last_out_cyc;
      last_out_cyc = cyc;
      last_out = out_sample;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid_out", 1, 0);
      end else begin
        chk("out_sample", out_sample, exp_q.pop_front());
      end
      if (dc_mode) begin
        dc_seen++;
        if (dc_seen > 8 && (out_sample > 16385 || out_sample < 16383)) dc_bad++;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic send(input logic signed [15:0] x, input int gap);
    valid_in = 1'b1;
    in_sample = x;
    @(posedge clk);
    #1 valid_in = 1'b0;
    model_accept(x);
    repeat (gap - 1) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    repeat (14) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    int n0;
    int p0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_out_sample", out_sample, 0);
    chk("reset_valid_out", valid_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overrun", overrun, 0);

    dc_mode = 1;
    for (int i = 0; i < 2000; i++) send(16'sd16384, 11);
    drain("dc_drain");
    dc_mode = 0;
    chk("dc_outputs_within_1", dc_bad, 0);
    chk("dc_enough_outputs", (dc_seen > 8), 1);

    do_reset();
    n0 = n_out;
    p0 = n_pushed;
    min_gap = 1000000;
    last_out_cyc = -1;
    for (int i = 0; i < 441; i++) send(16'($urandom), 20);
    drain("rate_drain");
    chk("rate_output_count", n_out - n0, (longint'(441) * STEP) / 65536);
    chk("rate_model_count", n_pushed - p0, (longint'(441) * STEP) / 65536);
    chk("rate_min_gap_ok", (min_gap >= 11), 1);

    do_reset();
    send(16'sd32767, 11);
    for (int i = 0; i < 30; i++) send(16'sd0, 11);
    drain("impulse_drain");

    do_reset();
    for (int i = 0; i < 300; i++) send(16'($urandom), $urandom_range(11, 15));
    drain("random_drain");

    do_reset();
    while (will_carry()) send(16'($urandom), 11);
    while (!will_carry()) send(16'($urandom), 11);
    valid_in = 1'b1;
    in_sample = 16'($urandom);
    @(posedge clk);
    #1 valid_in = 1'b0;
    model_accept(in_sample);
    repeat (2) @(posedge clk);
    #1 valid_in = 1'b1;
    in_sample = 16'sh7abc;
    @(posedge clk);
    #1 valid_in = 1'b0;
    @(negedge clk);
    chk("overrun_set", overrun, 1);
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) send(16'($urandom), 11);
    drain("overrun_drain");
    chk("overrun_sticky", overrun, 1);

    do_reset();
    while (will_carry()) send(16'sd1000, 11);
    while (!will_carry()) send(16'sd1000, 11);
    valid_in = 1'b1;
    in_sample = 16'sd20000;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    chk("abort_busy", busy, 0);
    chk("abort_out_sample", out_sample, 0);
    chk("abort_valid_out", valid_out, 0);
    chk("abort_overrun", overrun, 0);
    repeat (12) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) send(16'($urandom), 11);
    drain("abort_drain");

    do_reset();
    send(16'sd0, 11);
    send(-16'sd32768, 11);
    for (int i = 0; i < 6; i++) send(16'sd32767, 11);
    send(-16'sd32768, 11);
    drain("sat_drain");
`ifdef DS_SATURATE_EN
    chk("sat_value", last_out, 32767);
`else
    chk("wrap_value", last_out, -30721);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
